// File: rtl/mips_multi2.sv
// Multicycle MIPS-subset core: ROM fetch, cache request/stall handshake, retire strobe.
// Optional slt/bne support is enabled by defining MIPS_MULTI2_SLT_EN.
module mips_multi2 #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              r_en,
  output logic              w_en,
  input  logic              stall,
  input  logic [4:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_reg,
  output logic              retire,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StIr     = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  logic [DATA_W-1:0] regs_q [32];

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       is_rtype, is_add, is_sub, is_slt, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
  logic       is_branch, branch_take, supported;
  logic [4:0]        wb_idx;
  logic [DATA_W-1:0] wb_val;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];

  assign is_rtype = (opcode == 6'b000000);
  assign is_add   = is_rtype && (funct == 6'b100000);
  assign is_sub   = is_rtype && (funct == 6'b100010);
  assign is_addi  = (opcode == 6'b001000);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_j     = (opcode == 6'b000010);

`ifdef MIPS_MULTI2_SLT_EN
  assign is_slt   = is_rtype && (funct == 6'b101010);
  assign is_bne   = (opcode == 6'b000101);
`else
  assign is_slt   = 1'b0;
  assign is_bne   = 1'b0;
`endif

  assign is_branch   = is_beq || is_bne;
  assign branch_take = is_beq ? (a_q == b_q) : (a_q != b_q);
  assign supported   = is_add || is_sub || is_slt || is_addi || is_lw || is_sw || is_branch;

  always_comb begin
    wb_idx = is_rtype ? rd : rt;
    wb_val = is_lw ? mdr_q : alu_q;
  end

  assign imem_addr = pc_q;
  assign mem_addr  = alu_q[ADDR_W-1:0];
  assign mem_wdata = b_q;
  // Requests decode straight from state so an async reset drops them at once.
  assign r_en      = (state_q == StMem) && is_lw;
  assign w_en      = (state_q == StMem) && is_sw;
  assign retire    = ((state_q == StDecode) && (is_j || !supported)) ||
                     ((state_q == StExec) && is_branch) ||
                     ((state_q == StMem) && is_sw && !stall) ||
                     (state_q == StWb);
  assign dbg_reg   = regs_q[dbg_sel];
  assign state     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        StFetch: state_q <= StIr;
        StIr: begin
          ir_q    <= imem_data;
          pc_q    <= pc_q + PC_W'(1);
          state_q <= StDecode;
        end
        StDecode: begin
          a_q   <= regs_q[rs];
          b_q   <= regs_q[rt];
          imm_q <= DATA_W'($signed(ir_q[15:0]));
          if (is_j) begin
            pc_q    <= ir_q[PC_W-1:0];
            state_q <= StFetch;
          end else if (!supported) begin
            state_q <= StFetch;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (is_add)                         alu_q <= a_q + b_q;
          else if (is_sub)                    alu_q <= a_q - b_q;
          else if (is_slt)                    alu_q <= ($signed(a_q) < $signed(b_q)) ?
                                                       DATA_W'(1) : '0;
          else if (is_addi || is_lw || is_sw) alu_q <= a_q + imm_q;
          if (is_branch) begin
            // pc_q already points past the branch.
            if (branch_take) pc_q <= pc_q + imm_q[PC_W-1:0];
            state_q <= StFetch;
          end else if (is_lw || is_sw) begin
            state_q <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (!stall) begin
            if (is_lw) begin
              mdr_q   <= mem_rdata;
              state_q <= StWb;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StWb: begin
          if (wb_idx != 5'd0) regs_q[wb_idx] <= wb_val;
          state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi2.sv
// Directed table-driven bench for mips_multi2: one ROM instruction per row, then a
// hand-written reset-during-MEM sequence.
module tb_mips_multi2;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        r_en, w_en, stall, retire;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_reg;
  logic [2:0]  state;

  mips_multi2 #(.PC_W(10), .ADDR_W(12), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .r_en      (r_en),
    .w_en      (w_en),
    .stall     (stall),
    .dbg_sel   (dbg_sel),
    .dbg_reg   (dbg_reg),
    .retire    (retire),
    .state     (state)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [1024];
  always @(posedge clk) imem_data <= rom[imem_addr];

  typedef struct {
    int unsigned pc;
    logic [31:0] instr;
    int          stall_n;
    bit          noise;
    logic [31:0] rdata;
    int          cyc;
    int          ren;
    int          wen;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [4:0]  reg_i;
    logic [31:0] reg_v;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  // Results of the most recent run_one call.
  int          r_cyc, r_ren, r_wen;
  bit          r_both;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input int unsigned pc, input logic [31:0] instr, input int stall_n,
                     input bit noise, input logic [31:0] rdata, input int cyc, input int ren,
                     input int wen, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [4:0] reg_i, input logic [31:0] reg_v);
    vec_t v;
    v.pc = pc; v.instr = instr; v.stall_n = stall_n; v.noise = noise; v.rdata = rdata;
    v.cyc = cyc; v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.reg_i = reg_i; v.reg_v = reg_v;
    vq.push_back(v);
  endtask

  // Starts at the negedge of a FETCH cycle; returns at the negedge of the next FETCH.
  task automatic run_one(input int stall_n, input bit noise);
    int  left;
    bit  done;
    left = stall_n; done = 0;
    r_cyc = 0; r_ren = 0; r_wen = 0; r_both = 0; r_addr = '0; r_wdata = '0;
    while (!done && r_cyc < 40) begin
      r_cyc++;
      if (state == 3'd4) begin
        stall = (left != 0);
        if (left != 0) left--;
      end else begin
        stall = noise;
      end
      #1;
      if (r_en) r_ren++;
      if (w_en) r_wen++;
      if (r_en || w_en) begin
        r_addr  = mem_addr;
        r_wdata = mem_wdata;
      end
      if (r_en && w_en) r_both = 1;
      if (retire) done = 1;
      @(negedge clk);
    end
    stall = 1'b0;
  endtask

  int unsigned j_pc;
  int          bad_regs;
  bit          hit_mem;

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    rst = 1'b1; stall = 1'b0; mem_rdata = '0; dbg_sel = 5'd1;

`ifdef MIPS_MULTI2_SLT_EN
    j_pc = 11;
`else
    j_pc = 10;
`endif
    //   pc     instr         stl nz rdata       cyc ren wen addr   wdata  reg  value
    add(0,     32'h20010005, 0, 0, 32'h0,      5,  0,  0,  12'h0, 32'h0, 1,   32'h5);
    add(1,     32'h2002FFFD, 0, 0, 32'h0,      5,  0,  0,  12'h0, 32'h0, 2,   32'hFFFFFFFD);
    add(2,     32'h00221820, 0, 1, 32'h0,      5,  0,  0,  12'h0, 32'h0, 3,   32'h2);
    add(3,     32'h1021FFFF, 0, 0, 32'h0,      4,  0,  0,  12'h0, 32'h0, 1,   32'h5);
    add(3,     32'h00412022, 0, 0, 32'h0,      5,  0,  0,  12'h0, 32'h0, 4,   32'hFFFFFFF8);
    add(4,     32'h20000007, 0, 0, 32'h0,      5,  0,  0,  12'h0, 32'h0, 0,   32'h0);
    add(5,     32'hAC010008, 3, 0, 32'h0,      8,  0,  4,  12'h8, 32'h5, 1,   32'h5);
    add(6,     32'h8C050008, 0, 0, 32'h1234,   6,  1,  0,  12'h8, 32'h0, 5,   32'h1234);
    add(7,     32'h10220005, 0, 0, 32'h0,      4,  0,  0,  12'h0, 32'h0, 1,   32'h5);
`ifdef MIPS_MULTI2_SLT_EN
    add(8,     32'h0041302A, 0, 0, 32'h0,      5,  0,  0,  12'h0, 32'h0, 6,   32'h1);
    add(9,     32'h14220001, 0, 0, 32'h0,      4,  0,  0,  12'h0, 32'h0, 2,   32'hFFFFFFFD);
`else
    add(8,     32'h0041302A, 0, 0, 32'h0,      3,  0,  0,  12'h0, 32'h0, 6,   32'h0);
    add(9,     32'h14220001, 0, 0, 32'h0,      3,  0,  0,  12'h0, 32'h0, 2,   32'hFFFFFFFD);
`endif
    add(j_pc,  32'h080003F0, 0, 0, 32'h0,      3,  0,  0,  12'h0, 32'h0, 1,   32'h5);
    add(10'h3F0, 32'hFC000000, 0, 0, 32'h0,    3,  0,  0,  12'h0, 32'h0, 3,   32'h2);
    add(10'h3F1, 32'h00000008, 0, 0, 32'h0,    3,  0,  0,  12'h0, 32'h0, 4,   32'hFFFFFFF8);

    repeat (2) @(negedge clk);
    check("reset state", 32'(state), 32'd0);
    check("reset imem_addr", 32'(imem_addr), 32'd0);
    check("reset req", {30'd0, r_en, w_en}, 32'd0);
    check("reset retire", 32'(retire), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset R1", dbg_reg, 32'd0);
    rst = 1'b0;

    foreach (vq[n]) begin
      check($sformatf("row%0d fetch pc", n), 32'(imem_addr), 32'(vq[n].pc));
      check($sformatf("row%0d fetch state", n), 32'(state), 32'd0);
      rom[vq[n].pc] = vq[n].instr;
      mem_rdata = vq[n].rdata;
      run_one(vq[n].stall_n, vq[n].noise);
      check($sformatf("row%0d cycles", n), 32'(r_cyc), 32'(vq[n].cyc));
      check($sformatf("row%0d r_en cycles", n), 32'(r_ren), 32'(vq[n].ren));
      check($sformatf("row%0d w_en cycles", n), 32'(r_wen), 32'(vq[n].wen));
      check($sformatf("row%0d r_en&w_en", n), 32'(r_both), 32'd0);
      if (vq[n].ren + vq[n].wen > 0)
        check($sformatf("row%0d mem_addr", n), 32'(r_addr), 32'(vq[n].addr));
      if (vq[n].wen > 0)
        check($sformatf("row%0d mem_wdata", n), r_wdata, vq[n].wdata);
      dbg_sel = vq[n].reg_i;
      #1;
      check($sformatf("row%0d R%0d", n, vq[n].reg_i), dbg_reg, vq[n].reg_v);
    end

    // Reset while a stalled lw holds its request.
    check("pre-reset pc", 32'(imem_addr), 32'h3F2);
    rom[10'h3F2] = 32'h8C070008;
    stall = 1'b1;
    hit_mem = 0;
    for (int k = 0; k < 10 && !hit_mem; k++) begin
      if (state == 3'd4) hit_mem = 1;
      else @(negedge clk);
    end
    check("reached MEM", 32'(hit_mem), 32'd1);
    check("stalled r_en", 32'(r_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset r_en", 32'(r_en), 32'd0);
    check("async reset w_en", 32'(w_en), 32'd0);
    check("async reset state", 32'(state), 32'd0);
    check("async reset pc", 32'(imem_addr), 32'd0);
    bad_regs = 0;
    for (int r = 0; r < 32; r++) begin
      dbg_sel = 5'(r);
      #1;
      if (dbg_reg !== 32'd0) bad_regs++;
    end
    check("async reset nonzero regs", 32'(bad_regs), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dbg_sel = 5'd1;
    run_one(0, 0);
    check("post-reset addi cycles", 32'(r_cyc), 32'd5);
    #1;
    check("post-reset R1", dbg_reg, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
